// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and data memory (slave).
interface mem_stage_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic              ack;
    logic [31:0]       rdata;

    modport master (output req, we, addr, wdata, be, input ack, rdata);
    modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over req/ack, stalls upstream while busy.
// Optional MEM_STAGE_PERF_EN adds saturating stall-cycle and memory-op counters.
//
// state | meaning
// IDLE  | ready for a new op; non-memory and misaligned ops complete in one cycle
// WAIT  | memory request outstanding, upstream stalled until dmem ack
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [4:0]        rd_num,
    input  logic              register_write,
    input  logic [1:0]        register_src,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              is_word,
    mem_stage_if.master       dmem,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [4:0]        out_rd_num,
    output logic              out_register_write,
    output logic [1:0]        out_register_src,
    output logic              misaligned_exc
`ifdef MEM_STAGE_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_mem_ops
`endif
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              load_q;
    logic              word_q;
    logic [1:0]        off_q;
    logic [31:0]       alu_q;
    logic [4:0]        rd_q;
    logic              rw_q;
    logic [1:0]        src_q;

    logic mem_op;
    logic misaligned;

    assign mem_op     = mem_read | mem_write;
    assign misaligned = mem_op & is_word & (alu_result[1:0] != 2'b00);
    assign in_ready   = rst_b & (state == IDLE);

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;
    assign dmem.be    = be_q;

    function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                                 input logic        word,
                                                 input logic [1:0]  off);
        logic [7:0] b;
        b = rdata[{off, 3'b000} +: 8];
        return word ? rdata : {{24{b[7]}}, b};
    endfunction

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state              <= IDLE;
            req_q              <= 1'b0;
            we_q               <= 1'b0;
            addr_q             <= '0;
            wdata_q            <= '0;
            be_q               <= '0;
            load_q             <= 1'b0;
            word_q             <= 1'b0;
            off_q              <= '0;
            alu_q              <= '0;
            rd_q               <= '0;
            rw_q               <= 1'b0;
            src_q              <= '0;
            out_valid          <= 1'b0;
            out_alu_result     <= '0;
            out_mem_data       <= '0;
            out_rd_num         <= '0;
            out_register_write <= 1'b0;
            out_register_src   <= '0;
            misaligned_exc     <= 1'b0;
        end else begin
            out_valid      <= 1'b0;
            misaligned_exc <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (mem_op && !misaligned) begin
                            req_q   <= 1'b1;
                            we_q    <= mem_write;
                            addr_q  <= ADDR_W'({alu_result[31:2], 2'b00});
                            wdata_q <= is_word ? rt_data : {4{rt_data[7:0]}};
                            be_q    <= is_word ? 4'b1111 : (4'b0001 << alu_result[1:0]);
                            // a store wins when both read and write are set
                            load_q  <= ~mem_write;
                            word_q  <= is_word;
                            off_q   <= alu_result[1:0];
                            alu_q   <= alu_result;
                            rd_q    <= rd_num;
                            rw_q    <= register_write;
                            src_q   <= register_src;
                            state   <= WAIT;
                        end else begin
                            out_valid          <= 1'b1;
                            out_alu_result     <= alu_result;
                            out_mem_data       <= '0;
                            out_rd_num         <= rd_num;
                            out_register_write <= register_write & ~misaligned;
                            out_register_src   <= register_src;
                            misaligned_exc     <= misaligned;
                        end
                    end
                end
                WAIT: begin
                    if (dmem.ack) begin
                        req_q              <= 1'b0;
                        out_valid          <= 1'b1;
                        out_alu_result     <= alu_q;
                        out_mem_data       <= load_q ? load_extract(dmem.rdata, word_q, off_q) : '0;
                        out_rd_num         <= rd_q;
                        out_register_write <= rw_q;
                        out_register_src   <= src_q;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_STAGE_PERF_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            perf_stall_cycles <= '0;
            perf_mem_ops      <= '0;
        end else begin
            if (state == WAIT && perf_stall_cycles != 32'hFFFF_FFFF)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (state == IDLE && in_valid && mem_op && !misaligned && perf_mem_ops != 32'hFFFF_FFFF)
                perf_mem_ops <= perf_mem_ops + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage that sits directly downstream of the execute stage.
- Consumes the ALU result, store data, destination register and writeback controls.
- Performs loads and stores to data memory over a req/ack handshake and stalls the upstream stage while an access is outstanding.
- Presents registered results to writeback.

Parameters:
- ADDR_W, 32, data-memory address width.
- DATA_W, 32, data width; fixed at 32 for byte-lane logic.

Ports:
- clk  input  1  clock, rising edge
- rst_b  input  1  asynchronous active-low reset
- in_valid  input  1  upstream operation present
- in_ready  output  1  stage can accept; low = stall upstream
- alu_result  input  32  effective address or ALU value
- rt_data  input  32  store data
- rd_num  input  5  destination register
- register_write  input  1  writeback enable
- register_src  input  2  writeback mux select, passed through
- mem_read  input  1  load
- mem_write  input  1  store
- is_word  input  1  1 = word access, 0 = byte access
- dmem_req  output  1  memory request
- dmem_we  output  1  write enable
- dmem_addr  output  ADDR_W  word-aligned address ({alu_result[31:2],2'b00})
- dmem_wdata  output  32  write data
- dmem_be  output  4  byte enables
- dmem_ack  input  1  request completes this cycle; rdata valid
- dmem_rdata  input  32  read data
- out_valid  output  1  writeback bundle valid, 1-cycle pulse per op
- out_alu_result  output  32  registered alu_result
- out_mem_data  output  32  load data, sign-extended for bytes
- out_rd_num  output  5  registered rd_num
- out_register_write  output  1  registered writeback enable
- out_register_src  output  2  registered register_src
- misaligned_exc  output  1  1-cycle pulse, misaligned word access

Behaviour:
- Reset: all outputs 0; in_ready=1 once rst_b deasserts; FSM=IDLE.
- FSM states: IDLE and WAIT.
- IDLE:
  - in_ready=1; an op is accepted when in_valid=1.
  - Non-memory op: output registers load at the next edge (out_valid=1, latency 1); out_mem_data=0.
  - Memory op, aligned: request fields are latched, dmem_req=1 from the next cycle, then go to WAIT.
  - Word access with alu_result[1:0]!=0: no request. Next cycle out_valid=1, out_register_write=0, misaligned_exc=1.
- WAIT:
  - in_ready=0.
  - dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be stay stable until dmem_ack.
  - On the dmem_ack cycle: capture the writeback bundle, drop dmem_req at the next edge, return to IDLE.
  - out_valid=1 in the cycle after ack; a new op is accepted in that same cycle.
  - Minimum memory-op occupancy is 2 cycles.
- dmem_ack outside WAIT is ignored.
- mem_read=1 and mem_write=1 together: the store takes priority; out_mem_data=0.
- Word store: dmem_be=4'b1111, dmem_wdata=rt_data.
- Byte store:
  - dmem_be = 4'b0001 << alu_result[1:0].
  - dmem_wdata = {4{rt_data[7:0]}}.
- Word load: out_mem_data = dmem_rdata.
- Byte load: byte b = dmem_rdata[8*alu_result[1:0] +: 8], sign-extended to 32 bits.
- Stores: out_register_write is passed through unchanged.
- Reset asserted mid-WAIT: dmem_req drops to 0 asynchronously and the outstanding access is abandoned. The memory model must discard it; no out_valid is produced for it.
- No downstream backpressure: writeback always accepts.

Optional Feature:
- MEM_STAGE_PERF_EN defined: adds outputs perf_stall_cycles[31:0] and perf_mem_ops[31:0].
  - perf_stall_cycles counts cycles with in_ready=0.
  - perf_mem_ops counts issued memory requests.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- Not defined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Non-memory op: alu_result=0x00001234, rd_num=5, register_write=1 → next cycle out_valid=1, out_alu_result=0x00001234, out_rd_num=5; dmem_req stays 0.
- lw from 0x00000100, ack 3 cycles after req, rdata=0xDEADBEEF → dmem_req held stable 3 cycles, in_ready=0 throughout; out_mem_data=0xDEADBEEF with out_valid=1 the cycle after ack.
- sb to 0x00000103, rt_data=0x000000AB → dmem_be=4'b1000, dmem_wdata=0xABABABAB, dmem_we=1, dmem_addr=0x00000100.
- lb from 0x00000102, rdata=0x00800000 → out_mem_data=0xFFFFFF80.
- lw from 0x00000102 → no dmem_req; misaligned_exc=1 for 1 cycle with out_valid=1, out_register_write=0.
- rst_b low while in WAIT → dmem_req=0 immediately; after release in_ready=1, out_valid=0; a late dmem_ack is ignored.
